uart_rx_core: RTL and testbench

8N1 UART receiver for the user-project Wishbone UART peripheral. It sits between the mprj_io RX pad input and the Wishbone register slave. It oversamples the line with a programmable cycles-per-bit divisor and checks framing. Received bytes go into a small show-ahead FIFO that the register slave pops on RXDATA reads.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_fifo.sv | 44 ++++
 rtl/uart_rx_core.sv | 122 ++++++++++++
 tb/tb_uart_rx_core.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and framing constants.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

    localparam int UART_DIV_MIN   = 4;
    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO; an extra pointer MSB tells full from empty.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [W-1:0]             dout
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         push_ok, pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign push_ok = push && (!full || pop_ok);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, framing check, RX FIFO.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     cfg_en_i,
    input  logic [DIV_W-1:0]         cfg_div_i,
    input  logic                     rx_i,
    output logic                     rd_valid_o,
    output logic [7:0]               rd_data_o,
    input  logic                     rd_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     frame_err_o,
    output logic                     overrun_o,
    input  logic                     clr_err_i,
    output logic                     busy_o
);
    rx_state_e        state, next_state;
    logic             rx_meta, rx_s;
    logic [DIV_W-1:0] div_eff, div_q, cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick, push, ferr_set, ovr_set, fifo_full, fifo_empty;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign div_eff = (cfg_div_i < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : cfg_div_i;
    assign tick    = (cnt == '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!cfg_en_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (!rx_s) next_state = START;
                START:   if (tick) next_state = rx_s ? IDLE : DATA;
                DATA:    if (tick && bit_idx == 3'(UART_DATA_BITS - 1)) next_state = STOP;
                STOP:    if (tick) next_state = rx_s ? IDLE : BREAK;
                BREAK:   if (rx_s) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o   = (state != IDLE);
        push     = cfg_en_i && (state == STOP) && tick && rx_s;
        ferr_set = cfg_en_i && (state == STOP) && tick && !rx_s;
    end

    // Divisor is captured at the start edge so a mid-frame change waits for the next frame.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt     <= '0;
            div_q   <= DIV_W'(UART_DIV_MIN);
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE) begin
                if (cfg_en_i && !rx_s) begin
                    div_q <= div_eff;
                    cnt   <= (div_eff >> 1) - DIV_W'(1);
                end
            end else if (tick) begin
                cnt <= div_q - DIV_W'(1);
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
            if (state == START) bit_idx <= '0;
            if (state == DATA && tick) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign rd_valid_o = !fifo_empty;
    assign ovr_set    = push && fifo_full && !(rd_ready_i && rd_valid_o);

    uart_rx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push),
        .din   (shreg),
        .pop   (rd_ready_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o),
        .dout  (rd_data_o)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (ferr_set)       frame_err_o <= 1'b1;
            else if (clr_err_i) frame_err_o <= 1'b0;
            if (ovr_set)        overrun_o   <= 1'b1;
            else if (clr_err_i) overrun_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framing, FIFO boundaries, glitch, break and reset.
module tb_uart_rx_core;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst, en, rx, rdy, clr;
    logic [DIV_W-1:0] div;
    logic             rd_valid, ferr, ovr, busy;
    logic [7:0]       rd_data;
    logic [2:0]       level;
    int               n_checks = 0;
    int               n_err = 0;

    always #10 clk = ~clk;

    uart_rx_core #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cfg_en_i    (en),
        .cfg_div_i   (div),
        .rx_i        (rx),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .rd_ready_i  (rdy),
        .level_o     (level),
        .frame_err_o (ferr),
        .overrun_o   (ovr),
        .clr_err_i   (clr),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // All drive tasks begin and end on a falling edge.
    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input int bt);
        drive(1'b0, bt);
        for (int i = 0; i < 8; i++) drive(b[i], bt);
        drive(stop_bit, bt);
    endtask

    task automatic pop_one();
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        rx = 1'b1; rst = 1'b1; en = 1'b1; div = 16'd434; rdy = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", rd_valid, 0);
        check("rst_level", level, 0);
        check("rst_data", rd_data, 0);
        check("rst_ferr", ferr, 0);
        check("rst_ovr", ovr, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // 0xDE: stop-bit decision lands 4125 edges after the start edge is driven
        fork
            send(8'hDE, 1'b1, 434);
            begin
                repeat (4125) @(posedge clk);
                #1 check("de_valid_before", rd_valid, 0);
                @(posedge clk);
                #1 check("de_valid_after", rd_valid, 1);
                check("de_data", rd_data, 8'hDE);
                check("de_level", level, 1);
            end
        join
        check("de_ferr", ferr, 0);
        check("de_ovr", ovr, 0);
        check("de_busy", busy, 0);
        pop_one();
        check("de_pop_level", level, 0);
        check("de_pop_valid", rd_valid, 0);

        send(8'h64, 1'b1, 434);
        send(8'h65, 1'b1, 434);
        check("two_level", level, 2);
        check("two_head0", rd_data, 8'h64);
        pop_one();
        check("two_head1", rd_data, 8'h65);
        check("two_level1", level, 1);
        pop_one();
        check("two_level0", level, 0);

        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 1'b1, 434);
        check("ovr_level", level, 4);
        check("ovr_flag", ovr, 1);
        check("ovr_ferr", ferr, 0);
        pulse_clr();
        check("ovr_clr", ovr, 0);
        for (int i = 0; i < 4; i++) begin
            check("ovr_contents", rd_data, 8'h11 + 8'(i));
            pop_one();
        end
        check("ovr_drained", level, 0);

        send(8'hA5, 1'b0, 434);
        drive(1'b0, 3 * 434);
        check("brk_busy", busy, 1);
        check("brk_ferr", ferr, 1);
        check("brk_level", level, 0);
        drive(1'b1, 4);
        check("brk_idle", busy, 0);
        send(8'h3C, 1'b1, 434);
        check("brk_next_valid", rd_valid, 1);
        check("brk_next_data", rd_data, 8'h3C);
        check("brk_next_level", level, 1);
        pop_one();
        pulse_clr();
        check("ferr_clr", ferr, 0);

        // 100-cycle glitch: START gives up at the half-bit decision
        fork
            begin
                drive(1'b0, 100);
                drive(1'b1, 200);
            end
            begin
                repeat (219) @(posedge clk);
                #1 check("gl_busy_before", busy, 1);
                @(posedge clk);
                #1 check("gl_busy_after", busy, 0);
            end
        join
        check("gl_level", level, 0);
        check("gl_ferr", ferr, 0);
        check("gl_ovr", ovr, 0);

        div = 16'd2;
        drive(1'b1, 4);
        send(8'hC3, 1'b1, 4);
        drive(1'b1, 4);
        check("div4_valid", rd_valid, 1);
        check("div4_data", rd_data, 8'hC3);
        check("div4_level", level, 1);
        check("div4_ferr", ferr, 0);
        div = 16'd434;

        b = 8'h5A;
        drive(1'b0, 434);
        for (int i = 0; i < 4; i++) drive(b[i], 434);
        rx = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rd_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_ferr", ferr, 0);
        check("mid_rst_ovr", ovr, 0);
        rst = 1'b0;
        drive(1'b1, 4);
        send(b, 1'b1, 434);
        check("post_rst_valid", rd_valid, 1);
        check("post_rst_data", rd_data, 8'h5A);
        check("post_rst_level", level, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
